// File: rtl/ota_stim_pkg.sv
// rtl/ota_stim_pkg.sv - shared types and default constants for the OTA stimulus engine
package ota_stim_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int unsigned SETTLE_CYC_DEF = 64;
  localparam int unsigned WIN_LOG2_DEF   = 8;
  localparam int unsigned CODE_W_DEF     = 8;

endpackage

// File: rtl/ota_sd_mod.sv
// rtl/ota_sd_mod.sv - first-order sigma-delta modulator with registered differential outputs
module ota_sd_mod #(
  parameter int unsigned CODE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [CODE_W-1:0] code,
  output logic              sd_p,
  output logic              sd_n
);

  logic [CODE_W-1:0] r_acc;
  logic              r_sd_p;
  logic              r_sd_n;
  logic [CODE_W:0]   w_sum;

  assign w_sum = {1'b0, r_acc} + {1'b0, code};

  // Accumulate the code each cycle; the carry out is the bitstream, both polarities
  // registered together. Disabled means cleared accumulator and both outputs low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_sd_p <= 1'b0;
      r_sd_n <= 1'b0;
    end else if (en) begin
      r_acc  <= w_sum[CODE_W-1:0];
      r_sd_p <= w_sum[CODE_W];
      r_sd_n <= ~w_sum[CODE_W];
    end else begin
      r_acc  <= '0;
      r_sd_p <= 1'b0;
      r_sd_n <= 1'b0;
    end
  end

  assign sd_p = r_sd_p;
  assign sd_n = r_sd_n;

endmodule

// File: rtl/ota_sd_stim.sv
// rtl/ota_sd_stim.sv - sigma-delta stimulus generator with settle+measure high-cycle counter
module ota_sd_stim
  import ota_stim_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int unsigned WIN_LOG2   = WIN_LOG2_DEF,
  parameter int unsigned CODE_W     = CODE_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mod_en_i,
  input  logic [CODE_W-1:0]   code_i,
  input  logic                load_i,
  input  logic                start_i,
  input  logic                meas_i,
  output logic                sd_p_o,
  output logic                sd_n_o,
  output logic                busy_o,
  output logic [WIN_LOG2:0]   result_o,
  output logic                result_valid_o
);

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CODE_W-1:0]   r_code;
  logic [1:0]          r_sync;
  logic [15:0]         r_settle_cnt;
  logic [WIN_LOG2-1:0] r_win_cnt;
  logic [WIN_LOG2:0]   r_hi_cnt;
  logic [WIN_LOG2:0]   w_hi_nxt;
  logic [WIN_LOG2:0]   r_result;
  logic                r_result_valid;
  logic                w_busy;
  logic                w_settle_last;
  logic                w_win_last;
  logic                w_meas_s;

  assign w_meas_s      = r_sync[1];
  assign w_settle_last = (r_settle_cnt == SETTLE_LAST);
  assign w_win_last    = &r_win_cnt;
  assign w_hi_nxt      = r_hi_cnt + {{WIN_LOG2{1'b0}}, w_meas_s};

  ota_sd_mod #(
    .CODE_W (CODE_W)
  ) u_mod (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (mod_en_i),
    .code  (r_code),
    .sd_p  (sd_p_o),
    .sd_n  (sd_n_o)
  );

  // Two-flop synchroniser for the asynchronous comparator output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[0], meas_i};
    end
  end

  // Code register; frozen while a run is settling or measuring.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_code <= '0;
    end else if (load_i && !w_busy) begin
      r_code <= code_i;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state; start is only honoured from IDLE, so it is dropped in DONE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start_i)       w_state_nxt = SETTLE;
      SETTLE:  if (w_settle_last) w_state_nxt = MEASURE;
      MEASURE: if (w_win_last)    w_state_nxt = DONE;
      DONE:                       w_state_nxt = IDLE;
      default:                    w_state_nxt = IDLE;
    endcase
  end

  // FSM outputs; DONE is deliberately not busy so a load can land there.
  always_comb begin
    w_busy = 1'b0;
    case (r_state)
      SETTLE, MEASURE: w_busy = 1'b1;
      default:         w_busy = 1'b0;
    endcase
  end

  // Settle, window and high-cycle counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_settle_cnt <= '0;
      r_win_cnt    <= '0;
      r_hi_cnt     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_i) r_settle_cnt <= '0;
        end
        SETTLE: begin
          if (w_settle_last) begin
            r_win_cnt <= '0;
            r_hi_cnt  <= '0;
          end else begin
            r_settle_cnt <= r_settle_cnt + 16'd1;
          end
        end
        MEASURE: begin
          r_win_cnt <= r_win_cnt + 1'b1;
          r_hi_cnt  <= w_hi_nxt;
        end
        default: ;
      endcase
    end
  end

  // Result capture on the last measure edge so result and valid appear together in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result       <= '0;
      r_result_valid <= 1'b0;
    end else if (r_state == MEASURE && w_win_last) begin
      r_result       <= w_hi_nxt;
      r_result_valid <= 1'b1;
    end else begin
      r_result_valid <= 1'b0;
    end
  end

  assign busy_o         = w_busy;
  assign result_o       = r_result;
  assign result_valid_o = r_result_valid;

endmodule

// File: tb/tb_ota_sd_stim.sv
// tb/tb_ota_sd_stim.sv - self-checking bench for ota_sd_stim
module tb_ota_sd_stim;

  localparam int S  = 64;
  localparam int WL = 8;
  localparam int NW = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mod_en_i;
  logic [7:0]  code_i;
  logic        load_i;
  logic        start_i;
  logic        meas_i;
  logic        sd_p_o;
  logic        sd_n_o;
  logic        busy_o;
  logic [WL:0] result_o;
  logic        result_valid_o;

  ota_sd_stim dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mod_en_i       (mod_en_i),
    .code_i         (code_i),
    .load_i         (load_i),
    .start_i        (start_i),
    .meas_i         (meas_i),
    .sd_p_o         (sd_p_o),
    .sd_n_o         (sd_n_o),
    .busy_o         (busy_o),
    .result_o       (result_o),
    .result_valid_o (result_valid_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_no  = 0;
  int loop_mode = 0;

  bit     hist [0:65535];
  int     hist_base;
  int     m_code;
  longint m_phase;
  int     m_run_k;
  bit     e_sdp, e_sdn, e_busy, e_valid;
  int     e_result;

  typedef struct {
    logic [7:0] code;
    int         meas_mode;
    int         exp_result;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %0d expected %0d", name, edge_no, act, exp);
    end
  endtask

  task automatic model_reset();
    m_code   = 0;
    m_phase  = 0;
    m_run_k  = -1;
    e_sdp    = 0;
    e_sdn    = 0;
    e_busy   = 0;
    e_valid  = 0;
    e_result = 0;
  endtask

  // Count of synchronised highs seen over the window of a run started at edge k.
  function automatic int window_sum(input int k);
    int s = 0;
    for (int e = k + S + 1; e <= k + S + NW; e++) begin
      int idx = e - 2;
      if (idx >= hist_base && hist[idx]) s++;
    end
    return s;
  endfunction

  task automatic step();
    bit     pre_busy, pre_valid;
    longint nxt;
    @(posedge clk);
    edge_no++;
    if (!rst_n) begin
      model_reset();
      hist_base = edge_no + 1;
    end else begin
      hist[edge_no] = meas_i;
      pre_busy  = e_busy;
      pre_valid = e_valid;
      if (mod_en_i) begin
        nxt     = m_phase + longint'(m_code);
        e_sdp   = ((nxt / 256) != (m_phase / 256));
        e_sdn   = !e_sdp;
        m_phase = nxt;
      end else begin
        m_phase = 0;
        e_sdp   = 0;
        e_sdn   = 0;
      end
      if (load_i && !pre_busy) m_code = int'(code_i);
      e_valid = 0;
      if (m_run_k < 0) begin
        if (start_i && !pre_busy && !pre_valid) begin
          m_run_k = edge_no;
          e_busy  = 1;
        end
      end else if (edge_no - m_run_k == S + NW) begin
        e_busy   = 0;
        e_valid  = 1;
        e_result = window_sum(m_run_k);
        m_run_k  = -1;
      end
    end
    #1;
    chk("sd_p", int'(sd_p_o), int'(e_sdp));
    chk("sd_n", int'(sd_n_o), int'(e_sdn));
    chk("busy", int'(busy_o), int'(e_busy));
    chk("valid", int'(result_valid_o), int'(e_valid));
    chk("result", int'(result_o), e_result);
    if (loop_mode != 0) meas_i = sd_p_o;
  endtask

  task automatic run(input int inject_at, input logic [7:0] start_code, input bit with_load,
                     output int vidx, output int nbusy, output int nvalid);
    code_i  = start_code;
    load_i  = with_load;
    start_i = 1'b1;
    step();
    load_i  = 1'b0;
    start_i = 1'b0;
    nbusy   = int'(busy_o);
    vidx    = -1;
    nvalid  = 0;
    for (int i = 1; i <= 360; i++) begin
      if (i == inject_at) begin
        start_i = 1'b1;
        load_i  = 1'b1;
        code_i  = 8'h10;
      end
      step();
      start_i = 1'b0;
      load_i  = 1'b0;
      if (busy_o) nbusy++;
      if (result_valid_o) begin
        nvalid++;
        if (vidx < 0) vidx = i;
      end
    end
  endtask

  task automatic load_code(input logic [7:0] c);
    code_i = c;
    load_i = 1'b1;
    step();
    load_i = 1'b0;
  endtask

  initial begin
    int vidx, nbusy, nvalid, ones_p, ones_n, prev, lat;

    rst_n = 1'b0; mod_en_i = 1'b0; code_i = '0; load_i = 1'b0;
    start_i = 1'b0; meas_i = 1'b0;
    model_reset();
    hist_base = 1;
    step(); step();
    chk("reset_sd_p", int'(sd_p_o), 0);
    chk("reset_sd_n", int'(sd_n_o), 0);
    chk("reset_busy", int'(busy_o), 0);
    chk("reset_result", int'(result_o), 0);
    rst_n = 1'b1;
    step();

    // Density over a full 256-cycle span for a few codes.
    mod_en_i = 1'b1;
    load_code(8'h80);
    ones_p = 0; prev = int'(sd_p_o);
    for (int i = 0; i < 256; i++) begin
      step();
      ones_p += int'(sd_p_o);
      if (i > 0) chk("alt_0x80", int'(sd_p_o), 1 - prev);
      prev = int'(sd_p_o);
    end
    chk("density_0x80", ones_p, 128);
    load_code(8'h00);
    ones_p = 0; ones_n = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      ones_p += int'(sd_p_o);
      ones_n += int'(sd_n_o);
    end
    chk("density_0x00_p", ones_p, 0);
    chk("density_0x00_n", ones_n, 256);
    load_code(8'hFF);
    ones_p = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      ones_p += int'(sd_p_o);
    end
    chk("density_0xFF", ones_p, 255);

    // Table of full runs: code, how meas_i is driven, expected count.
    vecs[0] = '{8'h00, 1, 256};
    vecs[1] = '{8'h55, 0, 0};
    vecs[2] = '{8'h40, 2, 64};
    vecs[3] = '{8'h80, 2, 128};
    vecs[4] = '{8'hC0, 2, 192};
    vecs[5] = '{8'hFF, 2, 255};
    vecs[6] = '{8'h01, 2, 1};
    vecs[7] = '{8'h00, 2, 0};
    for (int v = 0; v < 8; v++) begin
      loop_mode = (vecs[v].meas_mode == 2) ? 1 : 0;
      if (vecs[v].meas_mode != 2) meas_i = (vecs[v].meas_mode == 1);
      load_code(vecs[v].code);
      step(); step(); step();
      run(-1, vecs[v].code, 1'b0, vidx, nbusy, nvalid);
      chk($sformatf("tbl%0d_result", v), int'(result_o), vecs[v].exp_result);
      chk($sformatf("tbl%0d_valid_at", v), vidx, S + NW);
      chk($sformatf("tbl%0d_busy_cycles", v), nbusy, S + NW);
      chk($sformatf("tbl%0d_pulses", v), nvalid, 1);
    end

    // Start and load during MEASURE are both dropped.
    loop_mode = 1;
    load_code(8'h40);
    step();
    run(S + 40, 8'h40, 1'b0, vidx, nbusy, nvalid);
    chk("ign_pulses", nvalid, 1);
    chk("ign_result", int'(result_o), 64);
    run(-1, 8'h40, 1'b0, vidx, nbusy, nvalid);
    chk("ign_code_kept", int'(result_o), 64);

    // Load and start on the same IDLE edge: the settle already uses the new code.
    load_code(8'h20);
    step();
    run(-1, 8'h80, 1'b1, vidx, nbusy, nvalid);
    chk("start_load_result", int'(result_o), 128);

    // Disable forces both outputs low; re-enable restarts from an empty accumulator.
    mod_en_i = 1'b0;
    step(); step();
    chk("dis_sd_p", int'(sd_p_o), 0);
    chk("dis_sd_n", int'(sd_n_o), 0);
    load_code(8'h80);
    step();
    mod_en_i = 1'b1;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (sd_p_o && lat < 0) lat = i;
    end
    chk("reenable_latency", lat, 2);

    // Reset in the middle of a run.
    loop_mode = 0;
    meas_i = 1'b1;
    code_i = 8'h00; start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int i = 1; i < 150; i++) step();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_mid_busy", int'(busy_o), 0);
    chk("rst_mid_result", int'(result_o), 0);
    chk("rst_mid_valid", int'(result_valid_o), 0);
    chk("rst_mid_sd_p", int'(sd_p_o), 0);
    chk("rst_mid_sd_n", int'(sd_n_o), 0);
    step(); step(); step();
    rst_n = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 250; i++) begin
      step();
      nvalid += int'(result_valid_o);
    end
    chk("rst_no_pulse", nvalid, 0);
    run(-1, 8'h00, 1'b0, vidx, nbusy, nvalid);
    chk("rst_rerun_result", int'(result_o), 256);

    // Random strobes, enable toggles and comparator activity against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(199) == 0) mod_en_i = ~mod_en_i;
      code_i  = 8'($urandom);
      load_i  = ($urandom_range(39) == 0);
      start_i = ($urandom_range(59) == 0);
      if (i == 2000) loop_mode = 1;
      if (loop_mode == 0) meas_i = 1'($urandom);
      step();
      load_i  = 1'b0;
      start_i = 1'b0;
    end
    loop_mode = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ota_sd_stim.md
Name: ota_sd_stim

Overview:
- Digital stimulus-and-measure engine for the digital OTA macro, the driving end of that analog interface.
- Generates a first-order sigma-delta differential bitstream that, after external RC filtering, forms the OTA input.
- Counts high cycles of the digitised OTA response over a fixed window and reports the count.
- Instantiated inside the tt_um top. Its outputs replace the constant-low tie-offs on uo_out/uio_out/uio_oe.

Parameters:
- SETTLE_CYC, 64: cycles the modulator runs before the measurement window opens (1..65535).
- WIN_LOG2, 8: measurement window is 2^WIN_LOG2 cycles (4..12).
- CODE_W, 8: width of the amplitude code.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset. One clock; all flops reset asynchronously on rst_n low.
- mod_en_i  in  1  modulator enable.
- code_i  in  CODE_W  amplitude code.
- load_i  in  1  one-cycle strobe; captures code_i.
- start_i  in  1  one-cycle strobe; starts a settle+measure run.
- meas_i  in  1  asynchronous digitised OTA output.
- sd_p_o  out  1  bitstream, true.
- sd_n_o  out  1  bitstream, complement.
- busy_o  out  1  high in SETTLE or MEASURE.
- result_o  out  WIN_LOG2+1  high-cycle count of the last completed window.
- result_valid_o  out  1  one-cycle pulse when result_o updates.

Behaviour:
- Reset values: code register 0, accumulator 0, sd_p_o 0, sd_n_o 0, busy_o 0, result_o 0, result_valid_o 0, FSM IDLE, synchroniser flops 0.
- Code load: load_i is accepted only when busy_o=0. load_i while busy is ignored and the code register is unchanged. A new code affects the modulator from the cycle after the capture edge.
- Modulator, mod_en_i=1: acc <= {1'b0,acc[CODE_W-1:0]} + code. sd_p_o is the registered carry (acc[CODE_W]). sd_n_o = ~sd_p_o, registered, so both outputs change on the same edge.
- Modulator density: exactly code ones per 2^CODE_W cycles. Code 0 gives constant 0. Code 255 gives 255 ones in 256.
- Modulator, mod_en_i=0: accumulator is cleared and both sd_p_o and sd_n_o are 0 (idle, matching the tie-off state). Re-enabling restarts from acc=0.
- meas_i passes through a 2-flop synchroniser, giving meas_s with 2-cycle latency. Only meas_s is counted.
- FSM IDLE: start_i=1 moves to SETTLE and clears the settle counter.
- FSM SETTLE: lasts SETTLE_CYC cycles, then moves to MEASURE with the window counter and the high counter cleared.
- FSM MEASURE: lasts 2^WIN_LOG2 cycles and adds meas_s each cycle. The counter is WIN_LOG2+1 bits wide and cannot overflow; a full-high window gives 2^WIN_LOG2.
- FSM DONE: one cycle. result_o is loaded and result_valid_o=1, then the FSM returns to IDLE.
- Run timing: start_i sampled at edge k gives SETTLE over cycles k+1..k+SETTLE_CYC, MEASURE over k+SETTLE_CYC+1..k+SETTLE_CYC+2^WIN_LOG2, and DONE in the next cycle. busy_o is low in DONE.
- start_i while busy or in DONE is ignored. There is no queueing.
- start_i and load_i together in IDLE: the code is captured and the run starts on the same edge, so the settle phase already uses the new code.
- mod_en_i may be toggled during a run. The run continues and the count reflects whatever the OTA produced.
- result_o holds its value between runs. It is never cleared except by reset.
- rst_n asserted mid-run aborts immediately to reset values. No result_valid_o pulse is produced.

Decomposition:
- Package ota_stim_pkg holds:
  - the state enum (IDLE, SETTLE, MEASURE, DONE);
  - default constants for SETTLE_CYC, WIN_LOG2 and CODE_W.
- Sub-module ota_sd_mod: accumulator plus registered differential outputs, with ports clk, rst_n, en, code, sd_p, sd_n.
- FSM, counters and synchroniser stay in ota_sd_stim.

Test Plan:
- Code density: mod_en_i=1, load code 0x80 -> sd_p_o alternates 1,0 and shows exactly 128 ones in any 256-cycle span. Load 0x00 -> sd_p_o constant 0, sd_n_o constant 1. Load 0xFF -> 255 ones per 256 cycles.
- Full/empty window: meas_i tied 1, start at edge k with defaults -> busy_o high k+1..k+320, result_valid_o pulses at k+321, result_o=256. Repeat with meas_i tied 0 -> result_o=0.
- Loopback: meas_i driven from sd_p_o with code 0x40 -> result_o=64.
- Ignored strobes: issue start_i and a load_i of 0x10 during MEASURE -> a single result_valid_o pulse and the code register is unchanged. start_i+load_i(0x80) together in IDLE with loopback -> result_o=128.
- Disable: mod_en_i=0 -> sd_p_o=sd_n_o=0. Re-enable with code 0x80 -> first sd_p_o=1 occurs 2 cycles after enable.
- Reset mid-run: assert rst_n low at cycle k+150 -> all outputs at reset values, no result_valid_o pulse. After release, a new run gives the correct result.
